// File: rtl/core_run_if.sv
// Run-control bundle between the core sequencer (master) and whoever starts runs and
// supplies core state (slave): start/pc/a0/exp_a0 in, reset/status/result out.
interface core_run_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [31:0]      pc;
  logic [31:0]      a0;
  logic [31:0]      exp_a0;
  logic             core_reset;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [31:0]      result;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  start, pc, a0, exp_a0,
    output core_reset, busy, done, pass, fail, timeout, result, cycle_count
  );

  modport slave (
    output start, pc, a0, exp_a0,
    input  core_reset, busy, done, pass, fail, timeout, result, cycle_count
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Core run sequencer: holds core in reset, releases on start, ends on PC hit or timeout; start ignored while busy.
// core_reset low RESET_CYCLES edges after start edge; done on the hit/limit edge. RUN_SIGCHECK_EN adds a0 check to pass.
module core_run_ctrl #(
  parameter logic [31:0] FIN_ADDR       = 32'h000000bc,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter int          RESET_CYCLES   = 2,
  parameter int          CNT_W          = 16
) (
  input  logic     clk,
  input  logic     reset,
  core_run_if.master bus
);
  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LIM   = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  state_t           state_q, state_n;
  logic             core_reset_q, core_reset_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             pass_q, pass_n;
  logic             fail_q, fail_n;
  logic             timeout_q, timeout_n;
  logic [31:0]      result_q, result_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic [HW-1:0]    hold_q, hold_n;
  logic             sig_ok;

`ifdef RUN_SIGCHECK_EN
  assign sig_ok = (bus.a0 == bus.exp_a0);
`else
  logic unused_exp_a0;
  assign unused_exp_a0 = ^bus.exp_a0;
  assign sig_ok        = 1'b1;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_n      = state_q;
    core_reset_n = core_reset_q;
    busy_n       = busy_q;
    done_n       = done_q;
    pass_n       = pass_q;
    fail_n       = fail_q;
    timeout_n    = timeout_q;
    result_n     = result_q;
    cnt_n        = cnt_q;
    hold_n       = hold_q;
    case (state_q)
      IDLE, DONE: begin
        core_reset_n = 1'b1;
        busy_n       = 1'b0;
        if (bus.start) begin
          state_n   = HOLD;
          busy_n    = 1'b1;
          done_n    = 1'b0;
          pass_n    = 1'b0;
          fail_n    = 1'b0;
          timeout_n = 1'b0;
          result_n  = '0;
          cnt_n     = '0;
          hold_n    = '0;
        end
      end
      HOLD: begin
        core_reset_n = 1'b1;
        busy_n       = 1'b1;
        if (hold_q == HOLD_LAST) begin
          state_n      = RUN;
          core_reset_n = 1'b0;
        end else begin
          hold_n = hold_q + 1'b1;
        end
      end
      RUN: begin
        core_reset_n = 1'b0;
        busy_n       = 1'b1;
        // A hit takes priority over reaching the limit on the same edge.
        if (bus.pc == FIN_ADDR) begin
          state_n      = DONE;
          core_reset_n = 1'b1;
          busy_n       = 1'b0;
          done_n       = 1'b1;
          result_n     = bus.a0;
          pass_n       = sig_ok;
          fail_n       = ~sig_ok;
        end else if (cnt_inc >= CNT_LIM) begin
          state_n      = DONE;
          core_reset_n = 1'b1;
          busy_n       = 1'b0;
          done_n       = 1'b1;
          timeout_n    = 1'b1;
          pass_n       = 1'b0;
          fail_n       = 1'b1;
          cnt_n        = CNT_LIM;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n      = IDLE;
        core_reset_n = 1'b1;
        busy_n       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      result_q     <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_n;
      core_reset_q <= core_reset_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
      pass_q       <= pass_n;
      fail_q       <= fail_n;
      timeout_q    <= timeout_n;
      result_q     <= result_n;
      cnt_q        <= cnt_n;
      hold_q       <= hold_n;
    end
  end

  assign bus.core_reset  = core_reset_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;
  assign bus.timeout     = timeout_q;
  assign bus.result      = result_q;
  assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: a PC model hits FIN_ADDR after a chosen number of RUN edges;
// expected run outcomes are queued at start and compared when done rises.
module tb_core_run_ctrl;
  localparam logic [31:0] FIN   = 32'h000000bc;
  localparam int          TO    = 100;
  localparam int          RSTC  = 2;
  localparam int          CW    = 16;

  typedef struct {
    logic          pass;
    logic          fail;
    logic          timeout;
    logic [31:0]   result;
    logic [CW-1:0] count;
  } exp_t;

  logic clk;
  logic reset;
  int   k;
  int   hit_at;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  core_run_if #(.CNT_W(CW)) bus ();

  core_run_ctrl #(
    .FIN_ADDR(FIN), .TIMEOUT_CYCLES(TO), .RESET_CYCLES(RSTC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: k counts RUN edges since release; pc reaches FIN when k == hit_at.
  always @(posedge clk) begin
    if (bus.core_reset) k <= 0;
    else                k <= k + 1;
  end
  assign bus.pc = (k == hit_at) ? FIN : (32'h00001000 + 32'(k) * 4);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_expect(input int hit, input logic [31:0] a0v, input logic [31:0] expv);
    exp_t e;
    if (hit < TO) begin
`ifdef RUN_SIGCHECK_EN
      e.pass = (a0v == expv);
`else
      e.pass = 1'b1;
`endif
      e.fail    = ~e.pass;
      e.timeout = 1'b0;
      e.result  = a0v;
      e.count   = CW'(hit);
    end else begin
      e.pass    = 1'b0;
      e.fail    = 1'b1;
      e.timeout = 1'b1;
      e.result  = 32'h0;
      e.count   = CW'(TO);
    end
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_and_check(input string tag, input int budget);
    exp_t e;
    int   n;
    n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, {31'b0, bus.done}, 32'h1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_pass"},       {31'b0, bus.pass},     {31'b0, e.pass});
      chk({tag, "_fail"},       {31'b0, bus.fail},     {31'b0, e.fail});
      chk({tag, "_timeout"},    {31'b0, bus.timeout},  {31'b0, e.timeout});
      chk({tag, "_result"},     bus.result,            e.result);
      chk({tag, "_count"},      32'(bus.cycle_count),  32'(e.count));
      chk({tag, "_core_reset"}, {31'b0, bus.core_reset}, 32'h1);
      chk({tag, "_busy"},       {31'b0, bus.busy},     32'h0);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    hit_at     = 20;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.a0     = 32'h0;
    bus.exp_a0 = 32'h0;
    #12;
    chk("rst_core_reset", {31'b0, bus.core_reset}, 32'h1);
    chk("rst_busy",       {31'b0, bus.busy},       32'h0);
    chk("rst_done",       {31'b0, bus.done},       32'h0);
    chk("rst_count",      32'(bus.cycle_count),    32'h0);
    chk("rst_result",     bus.result,              32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Normal run, including release latency
    hit_at     = 20;
    bus.a0     = 32'h00fff05f;
    bus.exp_a0 = 32'h00fff05f;
    push_expect(hit_at, bus.a0, bus.exp_a0);
    pulse_start();
    chk("norm_busy_e0",  {31'b0, bus.busy},       32'h1);
    chk("norm_crst_e0",  {31'b0, bus.core_reset}, 32'h1);
    @(negedge clk);
    chk("norm_crst_e1",  {31'b0, bus.core_reset}, 32'h1);
    @(negedge clk);
    chk("norm_crst_e2",  {31'b0, bus.core_reset}, 32'h0);
    wait_and_check("normal", 300);

    // Timeout: pc never reaches FIN within the limit
    hit_at = 1000;
    push_expect(hit_at, bus.a0, bus.exp_a0);
    pulse_start();
    wait_and_check("timeout", 300);

    // Boundary: hit on the TO-th sampled edge wins over timeout
    hit_at = TO - 1;
    bus.a0 = 32'h12345678;
    bus.exp_a0 = 32'h12345678;
    push_expect(hit_at, bus.a0, bus.exp_a0);
    pulse_start();
    wait_and_check("boundary", 300);

    // Start pulsed mid-RUN is ignored
    hit_at = 30;
    bus.a0 = 32'h00fff05f;
    bus.exp_a0 = 32'h00fff05f;
    push_expect(hit_at, bus.a0, bus.exp_a0);
    pulse_start();
    repeat (8) @(negedge clk);
    pulse_start();
    chk("midrun_busy",      {31'b0, bus.busy},       32'h1);
    chk("midrun_crst",      {31'b0, bus.core_reset}, 32'h0);
    wait_and_check("midrun", 300);

    // Start in DONE clears flags on the next edge and reruns identically
    push_expect(hit_at, bus.a0, bus.exp_a0);
    pulse_start();
    chk("restart_done",   {31'b0, bus.done},    32'h0);
    chk("restart_pass",   {31'b0, bus.pass},    32'h0);
    chk("restart_busy",   {31'b0, bus.busy},    32'h1);
    chk("restart_result", bus.result,           32'h0);
    chk("restart_count",  32'(bus.cycle_count), 32'h0);
    wait_and_check("restart", 300);

    // Signature check: mismatch then match
    hit_at     = 5;
    bus.exp_a0 = 32'h3;
    bus.a0     = 32'h2;
    push_expect(hit_at, bus.a0, bus.exp_a0);
    pulse_start();
    wait_and_check("sig_bad", 300);
    bus.a0 = 32'h3;
    push_expect(hit_at, bus.a0, bus.exp_a0);
    pulse_start();
    wait_and_check("sig_good", 300);

    // Async reset mid-RUN, between edges
    hit_at = 1000;
    pulse_start();
    repeat (10) @(negedge clk);
    chk("arst_pre_count", {31'b0, (bus.cycle_count != 0)}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_core_reset", {31'b0, bus.core_reset}, 32'h1);
    chk("arst_busy",       {31'b0, bus.busy},       32'h0);
    chk("arst_done",       {31'b0, bus.done},       32'h0);
    chk("arst_count",      32'(bus.cycle_count),    32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_busy",       {31'b0, bus.busy},       32'h0);
    chk("post_core_reset", {31'b0, bus.core_reset}, 32'h1);
    chk("post_done",       {31'b0, bus.done},       32'h0);
    chk("sb_drained",      32'(sb.size()),          32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
